// File: rtl/hazard_bypass_ctrl_if.sv
// rtl/hazard_bypass_ctrl_if.sv - operand/stage/hazard bundle between pipeline latches and bypass controller
interface hazard_bypass_ctrl_if #(
  parameter int NB_REG = 5,
  parameter int N_SRC  = 2,
  parameter int N_STG  = 2,
  parameter int NB_SEL = 3,
  parameter int NB_CNT = 16
);
  logic [N_SRC*NB_REG-1:0] i_ex_src;
  logic [N_SRC-1:0]        i_ex_src_use;
  logic [N_STG*NB_REG-1:0] i_stg_rd;
  logic [N_STG-1:0]        i_stg_we;
  logic [N_SRC*NB_REG-1:0] i_id_src;
  logic [N_SRC-1:0]        i_id_src_use;
  logic [NB_REG-1:0]       i_ex_rd;
  logic                    i_ex_mem_read;
  logic                    i_flush;
  logic                    i_halt;
  logic                    i_cnt_clr;
  logic [N_SRC*NB_SEL-1:0] o_fwd_sel;
  logic                    o_stall;
  logic                    o_bubble;
  logic [NB_CNT-1:0]       o_stall_cnt;

  modport master (
    output i_ex_src, i_ex_src_use, i_stg_rd, i_stg_we, i_id_src, i_id_src_use,
           i_ex_rd, i_ex_mem_read, i_flush, i_halt, i_cnt_clr,
    input  o_fwd_sel, o_stall, o_bubble, o_stall_cnt
  );

  modport slave (
    input  i_ex_src, i_ex_src_use, i_stg_rd, i_stg_we, i_id_src, i_id_src_use,
           i_ex_rd, i_ex_mem_read, i_flush, i_halt, i_cnt_clr,
    output o_fwd_sel, o_stall, o_bubble, o_stall_cnt
  );
endinterface

// File: rtl/hazard_bypass_ctrl.sv
// rtl/hazard_bypass_ctrl.sv - EX operand forwarding selects and load-use stall FSM with stall statistics
module hazard_bypass_ctrl #(
  parameter int NB_REG   = 5,
  parameter int N_SRC    = 2,
  parameter int N_STG    = 2,
  parameter int NB_SEL   = 3,
  parameter int LOAD_LAT = 1,
  parameter int NB_CNT   = 16
) (
  input logic             i_clk,
  input logic             i_reset_n,
  hazard_bypass_ctrl_if.slave bus
);

  typedef enum logic {ST_RUN, ST_STALL} state_e;

  localparam bit        MULTI_CYC = (LOAD_LAT > 1);
  localparam logic [3:0] LAT_M1   = 4'(LOAD_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NB_CNT-1:0]   stall_cnt_q, stall_cnt_d;
  logic [N_SRC*NB_SEL-1:0] fwd_sel;
  logic                haz;
  logic                id_hit;
  logic                stall;
  logic [NB_REG-1:0]   src;

  // Stages are scanned oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_sel = '0;
    src     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      src = bus.i_ex_src[k*NB_REG +: NB_REG];
      for (int j = N_STG - 1; j >= 0; j--) begin
        if (bus.i_ex_src_use[k] && bus.i_stg_we[j] &&
            (bus.i_stg_rd[j*NB_REG +: NB_REG] == src) && (src != '0)) begin
          fwd_sel[k*NB_SEL +: NB_SEL] = NB_SEL'(j + 1);
        end
      end
    end
  end

  always_comb begin
    id_hit = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (bus.i_id_src_use[k] && (bus.i_id_src[k*NB_REG +: NB_REG] == bus.i_ex_rd)) begin
        id_hit = 1'b1;
      end
    end
    haz = bus.i_ex_mem_read && (bus.i_ex_rd != '0) && id_hit;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = haz && !bus.i_flush;
        if (!bus.i_halt) begin
          if (bus.i_flush) begin
            cnt_d = '0;
          end else if (haz && MULTI_CYC) begin
            state_d = ST_STALL;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_STALL: begin
        // The load has already left EX, so a fresh hazard cannot extend this stall.
        stall = !bus.i_flush;
        if (!bus.i_halt) begin
          if (bus.i_flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = ST_RUN;
            end
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.i_halt) begin
      if (bus.i_cnt_clr) begin
        stall_cnt_d = '0;
      end else if (stall && (stall_cnt_q != {NB_CNT{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + {{(NB_CNT-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational outputs are forced quiet while reset is asserted.
  assign bus.o_fwd_sel   = i_reset_n ? fwd_sel : '0;
  assign bus.o_stall     = i_reset_n && stall;
  assign bus.o_bubble    = i_reset_n && stall;
  assign bus.o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// tb/tb_hazard_bypass_ctrl.sv - scoreboard bench for hazard_bypass_ctrl at LOAD_LAT 1 and 3
module tb_hazard_bypass_ctrl;

  localparam int NB_REG = 5;
  localparam int N_SRC  = 2;
  localparam int N_STG  = 2;
  localparam int NB_SEL = 3;

  logic clk = 1'b0;
  logic dut_rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_bypass_ctrl_if #(.NB_REG(NB_REG), .N_SRC(N_SRC), .N_STG(N_STG), .NB_SEL(NB_SEL), .NB_CNT(16)) if_a ();
  hazard_bypass_ctrl_if #(.NB_REG(NB_REG), .N_SRC(N_SRC), .N_STG(N_STG), .NB_SEL(NB_SEL), .NB_CNT(4))  if_b ();

  hazard_bypass_ctrl #(.NB_REG(NB_REG), .N_SRC(N_SRC), .N_STG(N_STG), .NB_SEL(NB_SEL),
                       .LOAD_LAT(1), .NB_CNT(16)) dut_a (
    .i_clk(clk), .i_reset_n(dut_rst_n), .bus(if_a));

  hazard_bypass_ctrl #(.NB_REG(NB_REG), .N_SRC(N_SRC), .N_STG(N_STG), .NB_SEL(NB_SEL),
                       .LOAD_LAT(3), .NB_CNT(4)) dut_b (
    .i_clk(clk), .i_reset_n(dut_rst_n), .bus(if_b));

  logic [9:0] ex_src, stg_rd, id_src;
  logic [1:0] ex_use, stg_we, id_use;
  logic [4:0] ex_rd;
  logic       mem_read, flush, halt, clr, rst_n;

  typedef struct {
    logic [5:0]  fwd;
    logic        stall_a;
    logic [15:0] cnt_a;
    logic        stall_b;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int rem_a = 0, cnt_a = 0, rem_b = 0, cnt_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Stall owed = cycles still to stall after this one; a load-use hazard costs lat cycles in total.
  task automatic model_step(input int lat, input int maxc, input logic hz,
                            inout int rem, inout int cnt, output logic st, output int cnt_now);
    if (!rst_n) begin
      st = 1'b0; rem = 0; cnt = 0; cnt_now = 0;
    end else begin
      cnt_now = cnt;
      st = (rem > 0) ? !flush : (hz && !flush);
      if (!halt) begin
        if (flush) rem = 0;
        else if (rem > 0) rem = rem - 1;
        else if (hz) rem = lat - 1;
        if (clr) cnt = 0;
        else if (st && cnt < maxc) cnt = cnt + 1;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    logic hz;
    int   sel, ca, cb;
    @(negedge clk);
    dut_rst_n = rst_n;
    if_a.i_ex_src = ex_src; if_a.i_ex_src_use = ex_use; if_a.i_stg_rd = stg_rd; if_a.i_stg_we = stg_we;
    if_a.i_id_src = id_src; if_a.i_id_src_use = id_use; if_a.i_ex_rd = ex_rd; if_a.i_ex_mem_read = mem_read;
    if_a.i_flush = flush; if_a.i_halt = halt; if_a.i_cnt_clr = clr;
    if_b.i_ex_src = ex_src; if_b.i_ex_src_use = ex_use; if_b.i_stg_rd = stg_rd; if_b.i_stg_we = stg_we;
    if_b.i_id_src = id_src; if_b.i_id_src_use = id_use; if_b.i_ex_rd = ex_rd; if_b.i_ex_mem_read = mem_read;
    if_b.i_flush = flush; if_b.i_halt = halt; if_b.i_cnt_clr = clr;
    hz = 1'b0;
    for (int k = 0; k < N_SRC; k++)
      if (id_use[k] && id_src[k*5 +: 5] == ex_rd) hz = 1'b1;
    hz = hz && mem_read && (ex_rd != 0);
    e.fwd = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sel = 0;
      for (int j = 0; j < N_STG; j++)
        if (sel == 0 && ex_use[k] && stg_we[j] && stg_rd[j*5 +: 5] == ex_src[k*5 +: 5] && ex_src[k*5 +: 5] != 0)
          sel = j + 1;
      if (rst_n) e.fwd[k*3 +: 3] = 3'(sel);
    end
    model_step(1, 65535, hz, rem_a, cnt_a, e.stall_a, ca);
    model_step(3, 15, hz, rem_b, cnt_b, e.stall_b, cb);
    e.cnt_a = 16'(ca);
    e.cnt_b = 4'(cb);
    sb.push_back(e);
  endtask

  task automatic idle_in();
    ex_src = '0; stg_rd = '0; id_src = '0; ex_use = '0; stg_we = '0; id_use = '0;
    ex_rd = '0; mem_read = 0; flush = 0; halt = 0; clr = 0; rst_n = 1;
  endtask

  task automatic load_use(input logic on);
    ex_rd = 5'd5; mem_read = on; id_src = {5'd0, 5'd5}; id_use = 2'b01;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("fwd_a",    32'(if_a.o_fwd_sel),   32'(e.fwd));
        chk("fwd_b",    32'(if_b.o_fwd_sel),   32'(e.fwd));
        chk("stall_a",  32'(if_a.o_stall),     32'(e.stall_a));
        chk("bubble_a", 32'(if_a.o_bubble),    32'(e.stall_a));
        chk("cnt_a",    32'(if_a.o_stall_cnt), 32'(e.cnt_a));
        chk("stall_b",  32'(if_b.o_stall),     32'(e.stall_b));
        chk("bubble_b", 32'(if_b.o_bubble),    32'(e.stall_b));
        chk("cnt_b",    32'(if_b.o_stall_cnt), 32'(e.cnt_b));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : driver
    idle_in();
    rst_n = 0; load_use(1);
    repeat (3) cycle();
    idle_in();
    cycle();
    // youngest stage wins, then older stage alone
    ex_src = {5'd7, 5'd3}; ex_use = 2'b11; stg_rd = {5'd3, 5'd3}; stg_we = 2'b11; cycle();
    stg_we = 2'b10; cycle();
    // $zero never forwarded, unused operand never forwarded
    ex_src = {5'd0, 5'd3}; stg_rd = {5'd0, 5'd0}; stg_we = 2'b11; cycle();
    ex_src = {5'd9, 5'd9}; ex_use = 2'b00; stg_rd = {5'd9, 5'd9}; cycle();
    idle_in();
    // single load-use hazard
    load_use(1); cycle();
    load_use(0); repeat (4) cycle();
    // flush in second stall cycle
    load_use(1); cycle();
    load_use(0); flush = 1; cycle();
    flush = 0; repeat (3) cycle();
    // halt during STALL
    load_use(1); cycle();
    load_use(0); halt = 1; repeat (4) cycle();
    halt = 0; repeat (4) cycle();
    // saturation, clear, reset mid-stall
    load_use(1); repeat (20) cycle();
    clr = 1; cycle();
    clr = 0; load_use(0); repeat (3) cycle();
    load_use(1); cycle();
    load_use(0); cycle();
    rst_n = 0; load_use(1); repeat (2) cycle();
    idle_in(); repeat (2) cycle();
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < N_SRC; k++) begin
        ex_src[k*5 +: 5] = 5'($urandom_range(0, 3));
        id_src[k*5 +: 5] = 5'($urandom_range(0, 3));
        stg_rd[k*5 +: 5] = 5'($urandom_range(0, 3));
      end
      ex_use   = 2'($urandom_range(0, 3));
      stg_we   = 2'($urandom_range(0, 3));
      id_use   = 2'($urandom_range(0, 3));
      ex_rd    = 5'($urandom_range(0, 3));
      mem_read = ($urandom_range(0, 1) == 1);
      flush    = ($urandom_range(0, 7) == 0);
      halt     = ($urandom_range(0, 7) == 0);
      clr      = !halt && ($urandom_range(0, 15) == 0);
      rst_n    = ($urandom_range(0, 63) != 0);
      cycle();
    end
    idle_in();
    @(negedge clk);
    #5;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
